// File: rtl/rvb_pcpi_issuer.sv
// PCPI initiator: takes one instruction plus operands, drives the PCPI bus until a
// responder completes it or a timeout marks it unclaimed, then returns the result.
module rvb_pcpi_issuer #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_insn,
    input  logic [31:0] req_rs1,
    input  logic [31:0] req_rs2,
    input  logic [31:0] req_rs3,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_wr,
    output logic [31:0] rsp_rd,
    output logic        rsp_trap,
    output logic        pcpi_valid,
    output logic [31:0] pcpi_insn,
    output logic [31:0] pcpi_rs1,
    output logic [31:0] pcpi_rs2,
    output logic [31:0] pcpi_rs3,
    input  logic        pcpi_wr,
    input  logic [31:0] pcpi_rd,
    input  logic        pcpi_wait,
    input  logic        pcpi_ready,
    output logic        err_proto
);
    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t      state_reg;
    logic [7:0]  cnt_reg;
    logic        claimed_reg;
    logic        req_ready_reg;
    logic        rsp_valid_reg;
    logic        rsp_wr_reg;
    logic [31:0] rsp_rd_reg;
    logic        rsp_trap_reg;
    logic        pcpi_valid_reg;
    logic [31:0] insn_reg, rs1_reg, rs2_reg, rs3_reg;
    logic        err_reg;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg      <= IDLE;
            cnt_reg        <= 8'd0;
            claimed_reg    <= 1'b0;
            req_ready_reg  <= 1'b0;
            rsp_valid_reg  <= 1'b0;
            rsp_wr_reg     <= 1'b0;
            rsp_rd_reg     <= 32'd0;
            rsp_trap_reg   <= 1'b0;
            pcpi_valid_reg <= 1'b0;
            insn_reg       <= 32'd0;
            rs1_reg        <= 32'd0;
            rs2_reg        <= 32'd0;
            rs3_reg        <= 32'd0;
            err_reg        <= 1'b0;
        end else begin
            // A responder may only answer while a request is on the bus.
            if ((pcpi_ready || pcpi_wait) && !pcpi_valid_reg)
                err_reg <= 1'b1;

            case (state_reg)
                IDLE: begin
                    req_ready_reg <= 1'b1;
                    if (req_valid && req_ready_reg) begin
                        insn_reg       <= req_insn;
                        rs1_reg        <= req_rs1;
                        rs2_reg        <= req_rs2;
                        rs3_reg        <= req_rs3;
                        cnt_reg        <= 8'd0;
                        claimed_reg    <= 1'b0;
                        req_ready_reg  <= 1'b0;
                        pcpi_valid_reg <= 1'b1;
                        state_reg      <= ISSUE;
                    end
                end
                ISSUE: begin
                    // Completion outranks wait and timeout expiry in the same cycle.
                    if (pcpi_ready) begin
                        rsp_wr_reg     <= pcpi_wr;
                        rsp_rd_reg     <= pcpi_rd;
                        rsp_trap_reg   <= 1'b0;
                        rsp_valid_reg  <= 1'b1;
                        pcpi_valid_reg <= 1'b0;
                        state_reg      <= RESP;
                    end else if (pcpi_wait) begin
                        claimed_reg <= 1'b1;
                    end else if (!claimed_reg) begin
                        if (cnt_reg == CNT_LAST) begin
                            rsp_wr_reg     <= 1'b0;
                            rsp_rd_reg     <= 32'd0;
                            rsp_trap_reg   <= 1'b1;
                            rsp_valid_reg  <= 1'b1;
                            pcpi_valid_reg <= 1'b0;
                            state_reg      <= RESP;
                        end else if (cnt_reg != 8'hFF) begin
                            cnt_reg <= cnt_reg + 8'd1;
                        end
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_reg <= 1'b0;
                        req_ready_reg <= 1'b1;
                        state_reg     <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign req_ready  = req_ready_reg;
    assign rsp_valid  = rsp_valid_reg;
    assign rsp_wr     = rsp_wr_reg;
    assign rsp_rd     = rsp_rd_reg;
    assign rsp_trap   = rsp_trap_reg;
    assign pcpi_valid = pcpi_valid_reg;
    assign pcpi_insn  = insn_reg;
    assign pcpi_rs1   = rs1_reg;
    assign pcpi_rs2   = rs2_reg;
    assign pcpi_rs3   = rs3_reg;
    assign err_proto  = err_reg;
endmodule

// File: tb/tb_rvb_pcpi_issuer.sv
// Testbench for rvb_pcpi_issuer: directed vector table, random responders checked
// against a scenario-level model, plus protocol-error and reset-during-issue sequences.
module tb_rvb_pcpi_issuer;
    localparam int TMO = 16;

    logic        clk = 1'b0;
    logic        resetn;
    logic        req_valid, req_ready;
    logic [31:0] req_insn, req_rs1, req_rs2, req_rs3;
    logic        rsp_valid, rsp_ready, rsp_wr, rsp_trap;
    logic [31:0] rsp_rd;
    logic        pcpi_valid;
    logic [31:0] pcpi_insn, pcpi_rs1, pcpi_rs2, pcpi_rs3;
    logic        pcpi_wr, pcpi_wait, pcpi_ready;
    logic [31:0] pcpi_rd;
    logic        err_proto;

    int checks = 0;
    int failures = 0;

    rvb_pcpi_issuer #(.TIMEOUT(TMO)) dut (
        .clk(clk), .resetn(resetn),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_insn(req_insn), .req_rs1(req_rs1), .req_rs2(req_rs2), .req_rs3(req_rs3),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_wr(rsp_wr),
        .rsp_rd(rsp_rd), .rsp_trap(rsp_trap),
        .pcpi_valid(pcpi_valid), .pcpi_insn(pcpi_insn),
        .pcpi_rs1(pcpi_rs1), .pcpi_rs2(pcpi_rs2), .pcpi_rs3(pcpi_rs3),
        .pcpi_wr(pcpi_wr), .pcpi_rd(pcpi_rd), .pcpi_wait(pcpi_wait), .pcpi_ready(pcpi_ready),
        .err_proto(err_proto)
    );

    always #5 clk = ~clk;

    // Responder scenario: wait held for cycles s..s+w-1 (w=0: never), ready pulsed
    // on cycle r (r=0: never); cycles count from 1 = first cycle of pcpi_valid.
    typedef struct {
        logic [31:0] insn, rs1, rs2, rs3, rd;
        logic        wr;
        int          s, w, r, delay;
        int          exp_cycles;
        logic        exp_trap, exp_wr;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t tbl[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [31:0] insn, input int s, input int w, input int r,
                                input logic [31:0] rd, input logic wr, input int delay,
                                input int ec, input logic et, input logic ew,
                                input logic [31:0] erd);
        vec_t v;
        v.insn = insn; v.rs1 = $urandom; v.rs2 = $urandom; v.rs3 = $urandom;
        v.rd = rd; v.wr = wr; v.s = s; v.w = w; v.r = r; v.delay = delay;
        v.exp_cycles = ec; v.exp_trap = et; v.exp_wr = ew; v.exp_rd = erd;
        return v;
    endfunction

    // Outcome from the rules alone: a wait seen before expiry claims the instruction,
    // otherwise a ready within TMO cycles completes it, otherwise it traps after TMO.
    function automatic vec_t model(input vec_t v);
        vec_t m = v;
        bit claimed = (v.w > 0) && (v.s <= TMO);
        if (claimed || (v.r > 0 && v.r <= TMO)) begin
            m.exp_cycles = v.r; m.exp_trap = 1'b0; m.exp_wr = v.wr; m.exp_rd = v.rd;
        end else begin
            m.exp_cycles = TMO; m.exp_trap = 1'b1; m.exp_wr = 1'b0; m.exp_rd = 32'd0;
        end
        return m;
    endfunction

    // Entered and left at a slot 1 time unit after a rising edge.
    task automatic run_txn(input vec_t v, input logic exp_err, input string tag);
        int c = 0;
        int bad = 0;
        int unstable = 0;
        logic [31:0] held_rd;
        chk("req_ready_before", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1;
        req_insn = v.insn; req_rs1 = v.rs1; req_rs2 = v.rs2; req_rs3 = v.rs3;
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_insn = $urandom; req_rs1 = $urandom; req_rs2 = $urandom; req_rs3 = $urandom;
        while (pcpi_valid && c < 300) begin
            c++;
            if (pcpi_insn !== v.insn || pcpi_rs1 !== v.rs1 || pcpi_rs2 !== v.rs2 ||
                pcpi_rs3 !== v.rs3 || req_ready !== 1'b0 || rsp_valid !== 1'b0)
                bad++;
            pcpi_wait  = (v.w > 0) && (c >= v.s) && (c < v.s + v.w);
            pcpi_ready = (c == v.r);
            pcpi_rd    = (c == v.r) ? v.rd : $urandom;
            pcpi_wr    = (c == v.r) ? v.wr : 1'($urandom);
            @(posedge clk); #1;
        end
        pcpi_wait = 1'b0; pcpi_ready = 1'b0;
        chk("issue_bus_stable", bad, 0);
        chk("valid_cycles", c, v.exp_cycles);
        chk("rsp_valid", {31'd0, rsp_valid}, 32'd1);
        chk("rsp_wr", {31'd0, rsp_wr}, {31'd0, v.exp_wr});
        chk("rsp_rd", rsp_rd, v.exp_rd);
        chk("rsp_trap", {31'd0, rsp_trap}, {31'd0, v.exp_trap});
        held_rd = rsp_rd;
        rsp_ready = 1'b0;
        for (int i = 0; i < v.delay; i++) begin
            @(posedge clk); #1;
            if (rsp_valid !== 1'b1 || rsp_rd !== held_rd || rsp_trap !== v.exp_trap ||
                req_ready !== 1'b0 || pcpi_valid !== 1'b0)
                unstable++;
        end
        if (v.delay > 0) chk("rsp_hold_stable", unstable, 0);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        chk("rsp_drained", {31'd0, rsp_valid}, 32'd0);
        chk("req_ready_after", {31'd0, req_ready}, 32'd1);
        chk("err_proto", {31'd0, err_proto}, {31'd0, exp_err});
        $display("txn %s insn=%h cycles=%0d trap=%b wr=%b rd=%h delay=%0d",
                 tag, v.insn, c, rsp_trap, rsp_wr, rsp_rd, v.delay);
    endtask

    initial begin
        vec_t v;
        resetn = 1'b0;
        req_valid = 1'b0; req_insn = '0; req_rs1 = '0; req_rs2 = '0; req_rs3 = '0;
        rsp_ready = 1'b0;
        pcpi_wr = 1'b0; pcpi_rd = '0; pcpi_wait = 1'b0; pcpi_ready = 1'b0;

        tbl[0] = mk(32'h6000_1013, 0, 0, 1,  32'h1234_5678, 1'b1, 0, 1,   1'b0, 1'b1, 32'h1234_5678);
        tbl[1] = mk(32'h6010_1093, 1, 40, 41, 32'hDEAD_BEEF, 1'b1, 0, 41,  1'b0, 1'b1, 32'hDEAD_BEEF);
        tbl[2] = mk(32'h0000_0013, 0, 0, 0,  32'hFFFF_FFFF, 1'b1, 0, TMO, 1'b1, 1'b0, 32'd0);
        tbl[3] = mk(32'h4820_1033, 0, 0, TMO, 32'h0000_00FF, 1'b1, 0, TMO, 1'b0, 1'b1, 32'h0000_00FF);
        tbl[4] = mk(32'h2800_5013, 0, 0, 3,  32'hA5A5_0F0F, 1'b0, 5, 3,   1'b0, 1'b0, 32'hA5A5_0F0F);
        tbl[5] = mk(32'h6020_1013, 0, 0, TMO + 1, 32'h1111_2222, 1'b1, 1, TMO, 1'b1, 1'b0, 32'd0);
        tbl[6] = mk(32'h6040_1013, TMO, 3, 25, 32'h3333_4444, 1'b1, 0, 25, 1'b0, 1'b1, 32'h3333_4444);
        tbl[7] = mk(32'h6050_1013, 2, 2, 30, 32'h5555_6666, 1'b1, 2, 30,  1'b0, 1'b1, 32'h5555_6666);

        repeat (3) @(posedge clk);
        #1;
        chk("reset_req_ready", {31'd0, req_ready}, 32'd0);
        chk("reset_pcpi_valid", {31'd0, pcpi_valid}, 32'd0);
        chk("reset_rsp", {29'd0, rsp_valid, rsp_wr, rsp_trap}, 32'd0);
        chk("reset_rsp_rd", rsp_rd, 32'd0);
        chk("reset_pcpi_insn", pcpi_insn, 32'd0);
        chk("reset_err", {31'd0, err_proto}, 32'd0);
        resetn = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 8; i++) run_txn(tbl[i], 1'b0, $sformatf("vec%0d", i));

        for (int i = 0; i < 40; i++) begin
            v = mk($urandom, 0, 0, 0, $urandom, 1'($urandom), $urandom_range(0, 3),
                   0, 1'b0, 1'b0, 32'd0);
            v.w = $urandom_range(0, 1) ? $urandom_range(1, 5) : 0;
            v.s = (v.w > 0) ? $urandom_range(1, 20) : 0;
            v.r = (v.w > 0) ? v.s + v.w + $urandom_range(0, 10) : $urandom_range(0, 25);
            run_txn(model(v), 1'b0, $sformatf("rnd%0d", i));
        end

        // Stray completion with nothing on the bus.
        pcpi_ready = 1'b1;
        @(posedge clk); #1;
        pcpi_ready = 1'b0;
        chk("err_set_by_stray", {31'd0, err_proto}, 32'd1);
        chk("stray_no_rsp", {31'd0, rsp_valid}, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("err_sticky", {31'd0, err_proto}, 32'd1);
        run_txn(tbl[0], 1'b1, "after_err");

        // Reset while an instruction is outstanding.
        req_valid = 1'b1; req_insn = 32'hCAFE_0013; req_rs1 = 32'h1; req_rs2 = 32'h2; req_rs3 = 32'h3;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("mid_issue_valid", {31'd0, pcpi_valid}, 32'd1);
        resetn = 1'b0;
        #1;
        chk("rst_drop_valid", {31'd0, pcpi_valid}, 32'd0);
        chk("rst_clear_err", {31'd0, err_proto}, 32'd0);
        chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
        chk("rst_pcpi_insn", pcpi_insn, 32'd0);
        @(posedge clk); #1;
        resetn = 1'b1;
        @(posedge clk); #1;
        chk("rst_no_rsp", {31'd0, rsp_valid}, 32'd0);
        chk("rst_req_ready_back", {31'd0, req_ready}, 32'd1);
        run_txn(tbl[3], 1'b0, "after_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
